// File: rtl/cc_frog_pkg.sv
// Shared types and constants for the frog game controller.
// State codes are visible on the State_Out port.
package cc_frog_pkg;

  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_HIT      = 3'd1,
    ST_NEST     = 3'd2,
    ST_LEVELUP  = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam int RESPAWN_COL = 3;
  localparam int LEVEL_W     = 2;
  localparam int LIVES_W     = 2;

endpackage

// File: rtl/cc_edge_detect.sv
// Single-bit rising-edge detector for debounced buttons.
// Output pulses for the one cycle where the input is high and was low.
module cc_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/cc_frog_control.sv
// Frog game controller: position, lives, level and game FSM.
// Drives one-hot row registers to the lane comparator.
module cc_frog_control
  import cc_frog_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int LIVES      = 3,
  parameter int HOLD_TICKS = 4
) (
  input  logic                CC_FROGCONTROL_CLOCK_50,
  input  logic                CC_FROGCONTROL_RESET_InLow,
  input  logic                CC_FROGCONTROL_Up_In,
  input  logic                CC_FROGCONTROL_Down_In,
  input  logic                CC_FROGCONTROL_Left_In,
  input  logic                CC_FROGCONTROL_Right_In,
  input  logic                CC_FROGCONTROL_Start_In,
  input  logic                CC_FROGCONTROL_Tick_In,
  input  logic                CC_FROGCONTROL_Lose_In,
  input  logic                CC_FROGCONTROL_Nest_In,
  input  logic                CC_FROGCONTROL_WinL_In,
  output logic [COLS-1:0]     CC_POINTREG_0,
  output logic [COLS-1:0]     CC_POINTREG_1,
  output logic [COLS-1:0]     CC_POINTREG_2,
  output logic [COLS-1:0]     CC_POINTREG_3,
  output logic [COLS-1:0]     CC_POINTREG_4,
  output logic [COLS-1:0]     CC_POINTREG_5,
  output logic [COLS-1:0]     CC_POINTREG_6,
  output logic [COLS-1:0]     CC_POINTREG_7,
  output logic [LEVEL_W-1:0]  CC_FROGCONTROL_Level_Out,
  output logic [LIVES_W-1:0]  CC_FROGCONTROL_Lives_Out,
  output logic                CC_FROGCONTROL_GameOver_Out,
  output logic [2:0]          CC_FROGCONTROL_State_Out
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic clk;
  logic rst_n;
  assign clk   = CC_FROGCONTROL_CLOCK_50;
  assign rst_n = CC_FROGCONTROL_RESET_InLow;

  logic w_up, w_dn, w_lf, w_rt, w_st;

  cc_edge_detect u_ed_up (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_d(CC_FROGCONTROL_Up_In), .o_rise(w_up)
  );
  cc_edge_detect u_ed_dn (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_d(CC_FROGCONTROL_Down_In), .o_rise(w_dn)
  );
  cc_edge_detect u_ed_lf (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_d(CC_FROGCONTROL_Left_In), .o_rise(w_lf)
  );
  cc_edge_detect u_ed_rt (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_d(CC_FROGCONTROL_Right_In), .o_rise(w_rt)
  );
  cc_edge_detect u_ed_st (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_d(CC_FROGCONTROL_Start_In), .o_rise(w_st)
  );

  state_t               r_state, w_nstate;
  logic [RW-1:0]        r_row, w_nrow;
  logic [CLW-1:0]       r_col, w_ncol;
  logic [LIVES_W-1:0]   r_lives, w_nlives;
  logic [LEVEL_W-1:0]   r_level, w_nlevel;
  logic [CW-1:0]        r_cnt, w_ncnt;
  logic [COLS-1:0]      r_pt [8];
  logic [COLS-1:0]      w_onehot;
  logic                 w_hold_done;
  logic                 w_top_row;

  assign w_hold_done = CC_FROGCONTROL_Tick_In &&
                       (r_cnt == CW'(HOLD_TICKS - 1));
  assign w_top_row   = (r_row == RW'(ROWS - 1));

  always_comb begin
    w_nstate = r_state;
    w_nrow   = r_row;
    w_ncol   = r_col;
    w_nlives = r_lives;
    w_nlevel = r_level;
    w_ncnt   = r_cnt;
    unique case (r_state)
      ST_PLAY: begin
        if (CC_FROGCONTROL_Lose_In) begin
          w_nstate = ST_HIT;
          if (r_lives != '0) w_nlives = r_lives - 1'b1;
        end else if (CC_FROGCONTROL_Nest_In && w_top_row) begin
          w_nstate = ST_NEST;
        end else if (CC_FROGCONTROL_WinL_In) begin
          w_nstate = ST_LEVELUP;
        end else if (w_up) begin
          if (!w_top_row) w_nrow = r_row + 1'b1;
        end else if (w_dn) begin
          if (r_row != '0) w_nrow = r_row - 1'b1;
        end else if (w_lf) begin
          if (r_col != CLW'(COLS - 1)) w_ncol = r_col + 1'b1;
        end else if (w_rt) begin
          if (r_col != '0) w_ncol = r_col - 1'b1;
        end
      end
      ST_HIT: begin
        if (w_hold_done) begin
          if (r_lives == '0) begin
            w_nstate = ST_GAMEOVER;
          end else begin
            w_nstate = ST_PLAY;
            w_nrow   = '0;
            w_ncol   = CLW'(RESPAWN_COL);
          end
        end else if (CC_FROGCONTROL_Tick_In) begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      ST_NEST: begin
        if (w_hold_done) begin
          w_nstate = ST_PLAY;
          w_nrow   = '0;
          w_ncol   = CLW'(RESPAWN_COL);
        end else if (CC_FROGCONTROL_Tick_In) begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      ST_LEVELUP: begin
        w_nstate = ST_PLAY;
        w_nlevel = r_level + 1'b1;
        w_nrow   = '0;
        w_ncol   = CLW'(RESPAWN_COL);
      end
      ST_GAMEOVER: begin
        if (w_st) begin
          w_nstate = ST_PLAY;
          w_nlives = LIVES_W'(LIVES);
          w_nlevel = '0;
          w_nrow   = '0;
          w_ncol   = CLW'(RESPAWN_COL);
        end
      end
      default: begin
        w_nstate = ST_PLAY;
        w_nrow   = '0;
        w_ncol   = CLW'(RESPAWN_COL);
      end
    endcase
    // hold counter restarts on every state entry
    if (w_nstate != r_state) w_ncnt = '0;
  end

  assign w_onehot = COLS'(1) << w_ncol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PLAY;
      r_row   <= '0;
      r_col   <= CLW'(RESPAWN_COL);
      r_lives <= LIVES_W'(LIVES);
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_row   <= w_nrow;
      r_col   <= w_ncol;
      r_lives <= w_nlives;
      r_level <= w_nlevel;
      r_cnt   <= w_ncnt;
    end
  end

  // row registers follow next-state so they line up with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++)
        r_pt[i] <= (i == 0) ? COLS'(1) << RESPAWN_COL : '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i < ROWS && w_nstate != ST_GAMEOVER &&
            w_nrow == RW'(i))
          r_pt[i] <= w_onehot;
        else
          r_pt[i] <= '0;
      end
    end
  end

  assign CC_POINTREG_0 = r_pt[0];
  assign CC_POINTREG_1 = r_pt[1];
  assign CC_POINTREG_2 = r_pt[2];
  assign CC_POINTREG_3 = r_pt[3];
  assign CC_POINTREG_4 = r_pt[4];
  assign CC_POINTREG_5 = r_pt[5];
  assign CC_POINTREG_6 = r_pt[6];
  assign CC_POINTREG_7 = r_pt[7];

  assign CC_FROGCONTROL_Level_Out    = r_level;
  assign CC_FROGCONTROL_Lives_Out    = r_lives;
  assign CC_FROGCONTROL_GameOver_Out = (r_state == ST_GAMEOVER);
  assign CC_FROGCONTROL_State_Out    = r_state;

endmodule

// File: tb/tb_cc_frog_control.sv
// Bench for cc_frog_control: game-rule model, per-cycle compare,
// directed scenarios with literal expectations, then random play.
module tb_cc_frog_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] btn = '0;   // 0 up, 1 down, 2 left, 3 right, 4 start
  logic tick = 1'b0;
  logic lose = 1'b0;
  logic nest = 1'b0;
  logic winl = 1'b0;

  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [1:0] lvl_o, lives_o;
  logic       go_o;
  logic [2:0] st_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cc_frog_control dut (
    .CC_FROGCONTROL_CLOCK_50(clk),
    .CC_FROGCONTROL_RESET_InLow(rst_n),
    .CC_FROGCONTROL_Up_In(btn[0]),
    .CC_FROGCONTROL_Down_In(btn[1]),
    .CC_FROGCONTROL_Left_In(btn[2]),
    .CC_FROGCONTROL_Right_In(btn[3]),
    .CC_FROGCONTROL_Start_In(btn[4]),
    .CC_FROGCONTROL_Tick_In(tick),
    .CC_FROGCONTROL_Lose_In(lose),
    .CC_FROGCONTROL_Nest_In(nest),
    .CC_FROGCONTROL_WinL_In(winl),
    .CC_POINTREG_0(p0),
    .CC_POINTREG_1(p1),
    .CC_POINTREG_2(p2),
    .CC_POINTREG_3(p3),
    .CC_POINTREG_4(p4),
    .CC_POINTREG_5(p5),
    .CC_POINTREG_6(p6),
    .CC_POINTREG_7(p7),
    .CC_FROGCONTROL_Level_Out(lvl_o),
    .CC_FROGCONTROL_Lives_Out(lives_o),
    .CC_FROGCONTROL_GameOver_Out(go_o),
    .CC_FROGCONTROL_State_Out(st_o)
  );

  // game-rule model: 0 play, 1 hit, 2 nest, 3 levelup, 4 gameover
  int m_state, m_row, m_col, m_lives, m_level, m_ticks;
  logic [4:0] m_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_row <= 0; m_col <= 3;
      m_lives <= 3; m_level <= 0; m_ticks <= 0;
      m_prev <= '0;
    end else begin
      automatic int s, r, c, l, lv, t;
      automatic logic [4:0] e;
      s = m_state; r = m_row; c = m_col;
      l = m_lives; lv = m_level; t = m_ticks;
      e = btn & ~m_prev;
      case (m_state)
        0: begin
          if (lose) begin
            s = 1; t = 0;
            l = (l > 0) ? l - 1 : 0;
          end else if (nest && r == 7) begin
            s = 2; t = 0;
          end else if (winl) begin
            s = 3;
          end else if (e[0]) r = (r < 7) ? r + 1 : 7;
          else if (e[1]) r = (r > 0) ? r - 1 : 0;
          else if (e[2]) c = (c < 7) ? c + 1 : 7;
          else if (e[3]) c = (c > 0) ? c - 1 : 0;
        end
        1, 2: begin
          if (tick) t = t + 1;
          if (t == 4) begin
            t = 0;
            if (m_state == 1 && l == 0) s = 4;
            else begin s = 0; r = 0; c = 3; end
          end
        end
        3: begin
          lv = (lv + 1) % 4; s = 0; r = 0; c = 3;
        end
        default: begin
          if (e[4]) begin
            s = 0; l = 3; lv = 0; r = 0; c = 3;
          end
        end
      endcase
      m_state <= s; m_row <= r; m_col <= c;
      m_lives <= l; m_level <= lv; m_ticks <= t;
      m_prev <= btn;
    end
  end

  function automatic logic [71:0] model_vec();
    logic [63:0] pts;
    pts = '0;
    if (m_state != 4) pts[m_row*8 + m_col] = 1'b1;
    return {pts, 2'(m_level), 2'(m_lives),
            (m_state == 4), 3'(m_state)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [71:0] act, exp_v;
      act = {p7, p6, p5, p4, p3, p2, p1, p0,
             lvl_o, lives_o, go_o, st_o};
      exp_v = model_vec();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, act, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  task automatic tap(input int k);
    btn[k] = 1'b1; @(negedge clk);
    btn[k] = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_lose();
    lose = 1'b1; @(negedge clk);
    lose = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_win();
    winl = 1'b1; @(negedge clk);
    winl = 1'b0; @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; @(negedge clk);
      tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", int'(st_o), 0);
    chk("reset_pt0", int'(p0), 8);
    chk("reset_lives", int'(lives_o), 3);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) tap(0);
    chk("up3_pt3", int'(p3), 8);
    chk("up3_pt0", int'(p0), 0);
    btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("held_up_pt4", int'(p4), 8);
    chk("held_up_pt5", int'(p5), 0);

    for (int i = 0; i < 6; i++) tap(2);
    chk("left_sat", int'(p4), 8'h80);
    for (int i = 0; i < 5; i++) tap(1);
    chk("down_sat", int'(p0), 8'h80);
    tap(3);
    chk("right", int'(p0), 8'h40);

    do_reset();
    pulse_lose();
    chk("hit_state", int'(st_o), 1);
    chk("hit_lives", int'(lives_o), 2);
    ticks(3);
    chk("hit_hold3", int'(st_o), 1);
    ticks(1);
    chk("hit_done_state", int'(st_o), 0);
    chk("hit_done_pt0", int'(p0), 8);

    for (int i = 0; i < 7; i++) tap(0);
    chk("top_pt7", int'(p7), 8);
    lose = 1'b1; nest = 1'b1; @(negedge clk);
    lose = 1'b0; nest = 1'b0; @(negedge clk);
    chk("lose_over_nest", int'(st_o), 1);
    ticks(4);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_lose();
      ticks(4);
    end
    chk("go_state", int'(st_o), 4);
    chk("go_flag", int'(go_o), 1);
    chk("go_pt0", int'(p0), 0);
    chk("go_lives", int'(lives_o), 0);
    pulse_lose();
    tap(0);
    chk("go_ignore", int'(st_o), 4);
    tap(4);
    chk("start_state", int'(st_o), 0);
    chk("start_lives", int'(lives_o), 3);
    chk("start_level", int'(lvl_o), 0);
    chk("start_pt0", int'(p0), 8);

    for (int i = 0; i < 3; i++) pulse_win();
    chk("level3", int'(lvl_o), 3);
    pulse_win();
    chk("level_wrap", int'(lvl_o), 0);

    pulse_lose();
    ticks(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(st_o), 0);
    chk("async_pt0", int'(p0), 8);
    chk("async_lives", int'(lives_o), 3);
    chk("async_go", int'(go_o), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 5) == 0) btn[k] = ~btn[k];
      if ($urandom_range(0, 3) == 0) btn[0] = 1'b0;
      tick = ($urandom_range(0, 2) == 0);
      lose = ($urandom_range(0, 49) == 0);
      nest = ($urandom_range(0, 3) == 0);
      winl = ($urandom_range(0, 79) == 0);
    end
    btn = '0; tick = 0; lose = 0; nest = 0; winl = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
